q1_sum_arbiter: RTL and testbench

Round-robin scheduler that shares one 8-sample summing engine (`go_in`/`d_in[7:0]` → `valid_out`/`data_out[10:0]`) between N requesters. It grants one requester at a time and streams that requester's bytes into the engine for exactly SAMPLES cycles. It then waits for the engine's sum and returns the sum tagged with the requester id. A timeout flags an engine that never answers. The block sits between the requester clients and the shared engine instance.

---
 rtl/q1_arb_pkg.sv | 36 +++
 rtl/q1_sum_arbiter_rr_pick.sv | 26 ++
 rtl/q1_sum_arbiter.sv | 117 +++++++++++
 tb/tb_q1_sum_arbiter.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/q1_arb_pkg.sv
// Shared types and helpers for the round-robin summing-engine arbiter.
package q1_arb_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned SUM_W  = 11;
    localparam int unsigned MAX_N  = 8;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        WAIT,
        DONE
    } arb_state_t;

    // First requester at or above ptr, searching upward and wrapping at n.
    function automatic logic [2:0] rr_first(
        input logic [MAX_N-1:0] req,
        input logic [2:0]       ptr,
        input int unsigned      n
    );
        logic [2:0]  win;
        logic        found;
        int unsigned j;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_N; k++) begin
            j = (32'(ptr) + k) % n;
            if (k < n && !found && req[j[2:0]]) begin
                found = 1'b1;
                win   = j[2:0];
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/q1_sum_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: picks the first active request at or after ptr.
module rr_pick
    import q1_arb_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           valid,
    output logic [IDW-1:0] idx
);

    logic [MAX_N-1:0] req_w;
    logic [2:0]       ptr_w;

    always_comb begin
        req_w          = '0;
        req_w[N-1:0]   = req;
        ptr_w          = '0;
        ptr_w[IDW-1:0] = ptr;
        valid          = |req;
        idx            = IDW'(rr_first(req_w, ptr_w, N));
    end

endmodule

// File: rtl/q1_sum_arbiter.sv
// Round-robin scheduler sharing one 8-sample summing engine among N requesters;
// each job streams SAMPLES bytes, waits for the sum (or a timeout) and returns it tagged.
module q1_sum_arbiter
    import q1_arb_pkg::*;
#(
    parameter  int unsigned N       = 4,
    parameter  int unsigned SAMPLES = 8,
    parameter  int unsigned TIMEOUT = 32,
    localparam int unsigned IDW     = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        req,
    input  logic [8*N-1:0]      d_flat,
    output logic [N-1:0]        gnt,
    output logic [N-1:0]        sample_ack,
    output logic                eng_go,
    output logic [DATA_W-1:0]   eng_d,
    input  logic                eng_valid,
    input  logic [SUM_W-1:0]    eng_data,
    output logic                res_valid,
    output logic [IDW-1:0]      res_id,
    output logic [SUM_W-1:0]    res_data,
    output logic                res_err
);

    localparam int unsigned TW = $clog2(TIMEOUT) + 1;

    arb_state_t        state;
    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    win;
    logic [IDW-1:0]    pick_idx;
    logic              pick_valid;
    logic [2:0]        cnt;
    logic [TW-1:0]     tcnt;
    logic [DATA_W-1:0] bytes [N];

    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Byte mux stays combinational so a requester can advance right after each ack.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            bytes[i] = d_flat[i*DATA_W +: DATA_W];
        end
        eng_d = eng_go ? bytes[win] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            win        <= '0;
            cnt        <= '0;
            tcnt       <= '0;
            gnt        <= '0;
            sample_ack <= '0;
            eng_go     <= 1'b0;
            res_valid  <= 1'b0;
            res_id     <= '0;
            res_data   <= '0;
            res_err    <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        win        <= pick_idx;
                        gnt        <= N'(1) << pick_idx;
                        sample_ack <= N'(1) << pick_idx;
                        eng_go     <= 1'b1;
                        cnt        <= '0;
                        state      <= STREAM;
                    end
                end
                STREAM: begin
                    if (cnt == 3'(SAMPLES - 1)) begin
                        eng_go     <= 1'b0;
                        sample_ack <= '0;
                        tcnt       <= '0;
                        state      <= WAIT;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                WAIT: begin
                    if (eng_valid) begin
                        res_valid <= 1'b1;
                        res_id    <= win;
                        res_data  <= eng_data;
                        res_err   <= 1'b0;
                        state     <= DONE;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        res_valid <= 1'b1;
                        res_id    <= win;
                        res_data  <= '0;
                        res_err   <= 1'b1;
                        state     <= DONE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                DONE: begin
                    gnt   <= '0;
                    ptr   <= (win == IDW'(N - 1)) ? '0 : win + IDW'(1);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_q1_sum_arbiter.sv
// Scoreboard bench for q1_sum_arbiter with a behavioural summing engine and requester byte sources.
module tb_q1_sum_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned S   = 8;
    localparam int unsigned T   = 32;
    localparam int unsigned IDW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [8*N-1:0]   d_flat;
    logic [N-1:0]     gnt;
    logic [N-1:0]     sample_ack;
    logic             eng_go;
    logic [7:0]       eng_d;
    logic             eng_valid;
    logic [10:0]      eng_data;
    logic             res_valid;
    logic [IDW-1:0]   res_id;
    logic [10:0]      res_data;
    logic             res_err;

    q1_sum_arbiter #(.N(N), .SAMPLES(S), .TIMEOUT(T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .d_flat     (d_flat),
        .gnt        (gnt),
        .sample_ack (sample_ack),
        .eng_go     (eng_go),
        .eng_d      (eng_d),
        .eng_valid  (eng_valid),
        .eng_data   (eng_data),
        .res_valid  (res_valid),
        .res_id     (res_id),
        .res_data   (res_data),
        .res_err    (res_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int data;
        int err;
    } exp_t;

    exp_t         sb_q[$];
    int           checks   = 0;
    int           failures = 0;
    logic [7:0]   byte_mem [N][8];
    int           pos [N];
    logic [N-1:0] ack_prev;
    int           eng_lat  = 2;
    int           inj_req  = 0;
    int           clr_req  = 0;

    int           grant_q[$];
    int           go_cnt, ack_cnt, onehot_bad, hold_bad, ack_bad, d_bad, res_cnt;
    int           min_gap, last_fall, cyc;

    function automatic int sum_of(input int i);
        int s;
        s = 0;
        for (int k = 0; k < 8; k++) s += int'(byte_mem[i][k]);
        return s;
    endfunction

    // Engine: sums bytes while eng_go, answers eng_lat cycles after the last byte (0 = never).
    initial begin
        int   acc, cd, inj_done;
        logic go_prev;
        acc = 0; cd = 0; inj_done = 0; go_prev = 1'b0;
        eng_valid = 1'b0;
        eng_data  = '0;
        forever begin
            @(negedge clk);
            eng_valid = 1'b0;
            if (eng_go && !go_prev) acc = 0;
            if (eng_go) acc += int'(eng_d);
            if (!eng_go && go_prev && eng_lat > 0) cd = eng_lat;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    eng_valid = 1'b1;
                    eng_data  = 11'(acc);
                end
            end
            if (inj_req != inj_done) begin
                inj_done  = inj_req;
                eng_valid = 1'b1;
                eng_data  = 11'd123;
            end
            go_prev = eng_go;
        end
    end

    // Requesters: present byte pos[i]; advance on the cycle after each sample_ack.
    initial begin
        for (int i = 0; i < N; i++) begin
            pos[i] = 0;
            for (int k = 0; k < 8; k++) byte_mem[i][k] = 8'(i + k);
        end
        d_flat   = '0;
        ack_prev = '0;
        forever begin
            @(negedge clk);
            ack_prev = sample_ack;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (!gnt[i]) pos[i] = 0;
                else if (ack_prev[i]) pos[i] = pos[i] + 1;
                d_flat[8*i +: 8] = byte_mem[i][pos[i] % 8];
            end
        end
    end

    // Protocol monitor.
    initial begin
        logic [N-1:0] prev_gnt;
        int           clr_done;
        prev_gnt = '0; clr_done = 0; cyc = 0;
        go_cnt = 0; ack_cnt = 0; onehot_bad = 0; hold_bad = 0; ack_bad = 0; d_bad = 0;
        res_cnt = 0; min_gap = 1000; last_fall = -1;
        forever begin
            @(negedge clk);
            cyc++;
            if (clr_req != clr_done) begin
                clr_done = clr_req;
                go_cnt = 0; ack_cnt = 0; onehot_bad = 0; hold_bad = 0; ack_bad = 0; d_bad = 0;
                res_cnt = 0; min_gap = 1000; last_fall = -1;
                grant_q.delete();
            end
            if (eng_go) go_cnt++;
            ack_cnt += $countones(sample_ack);
            if (gnt != '0 && !$onehot(gnt)) onehot_bad++;
            if (gnt != '0 && prev_gnt != '0 && gnt != prev_gnt) hold_bad++;
            if ((sample_ack & ~gnt) != '0) ack_bad++;
            if (!eng_go && eng_d != 8'd0) d_bad++;
            if (res_valid) res_cnt++;
            if (prev_gnt != '0 && gnt == '0) last_fall = cyc;
            if (prev_gnt == '0 && gnt != '0) begin
                for (int i = 0; i < N; i++) if (gnt[i]) grant_q.push_back(i);
                if (last_fall >= 0 && (cyc - last_fall) < min_gap) min_gap = cyc - last_fall;
            end
            prev_gnt = gnt;
        end
    end

    task automatic mon_clear();
        clr_req++;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
    endtask

    // Waits (bounded) for res_valid; counts grant cycles inclusive of the result cycle.
    task automatic wait_res(input int maxc, input int drop_at, output bit got,
                            output int gcyc, output logic [N-1:0] first_gnt);
        got = 1'b0; gcyc = 0; first_gnt = '0;
        for (int k = 0; k < maxc && !got; k++) begin
            @(negedge clk);
            if (gnt != '0) begin
                gcyc++;
                if (first_gnt == '0) first_gnt = gnt;
                if (gcyc == drop_at) req = '0;
            end
            if (res_valid) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (gnt !== '0) begin failures++; $display("FAIL reset_gnt: got %b want 0", gnt); end
        checks++;
        if (sample_ack !== '0) begin failures++; $display("FAIL reset_ack: got %b want 0", sample_ack); end
        checks++;
        if ({eng_go, eng_d} !== 9'd0) begin
            failures++; $display("FAIL reset_eng: go=%b d=%0d want 0/0", eng_go, eng_d);
        end
        checks++;
        if ({res_valid, res_id, res_data, res_err} !== '0) begin
            failures++;
            $display("FAIL reset_res: v=%b id=%0d data=%0d err=%b want all 0", res_valid, res_id, res_data, res_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        bit           got;
        int           gc;
        logic [N-1:0] fg;
        exp_t         e;
        byte_mem[0] = '{8'd5, 8'd3, 8'd7, 8'd8, 8'd5, 8'd3, 8'd2, 8'd1};
        eng_lat = 2;
        mon_clear();
        sb_q.push_back('{id: 0, data: 34, err: 0});
        req = 4'b0001;
        wait_res(100, 1, got, gc, fg);
        checks++;
        if (!got) begin
            failures++; $display("FAIL single_timeout: no res_valid in 100 cycles");
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (res_id !== IDW'(e.id)) begin failures++; $display("FAIL single_id: got %0d want %0d", res_id, e.id); end
            checks++;
            if (res_data !== 11'(e.data)) begin failures++; $display("FAIL single_data: got %0d want %0d", res_data, e.data); end
            checks++;
            if (res_err !== 1'(e.err)) begin failures++; $display("FAIL single_err: got %b want %0d", res_err, e.err); end
            checks++;
            if (gc != S + 2 + 1) begin failures++; $display("FAIL single_latency: got %0d want %0d", gc, S + 3); end
        end
        checks++;
        if (fg !== 4'b0001) begin failures++; $display("FAIL single_gnt: got %b want 0001", fg); end
        repeat (3) @(negedge clk);
        checks++;
        if (go_cnt != S) begin failures++; $display("FAIL single_go_cycles: got %0d want %0d", go_cnt, S); end
        checks++;
        if (ack_cnt != S) begin failures++; $display("FAIL single_acks: got %0d want %0d", ack_cnt, S); end
        checks++;
        if (d_bad != 0 || ack_bad != 0) begin
            failures++; $display("FAIL single_idle_outputs: d_bad=%0d ack_bad=%0d want 0/0", d_bad, ack_bad);
        end
    endtask

    task automatic test_contention();
        bit           got;
        int           gc;
        logic [N-1:0] fg;
        exp_t         e;
        bit           order_ok;
        do_reset();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 8; k++) byte_mem[i][k] = 8'(16 * i + k + 1);
        eng_lat = 3;
        mon_clear();
        for (int j = 0; j < 5; j++) sb_q.push_back('{id: j % 4, data: sum_of(j % 4), err: 0});
        req = '1;
        for (int j = 0; j < 5; j++) begin
            wait_res(200, 0, got, gc, fg);
            checks++;
            if (!got) begin
                failures++; $display("FAIL contention_timeout: job %0d no res_valid", j);
            end else begin
                e = sb_q.pop_front();
                checks++;
                if ({res_id, res_data, res_err} !== {IDW'(e.id), 11'(e.data), 1'(e.err)}) begin
                    failures++;
                    $display("FAIL contention_result job %0d: got id=%0d data=%0d err=%b want id=%0d data=%0d err=%0d",
                             j, res_id, res_data, res_err, e.id, e.data, e.err);
                end
                checks++;
                if (gc != S + 3 + 1) begin
                    failures++; $display("FAIL contention_latency job %0d: got %0d want %0d", j, gc, S + 4);
                end
            end
        end
        req = '0;
        repeat (4) @(negedge clk);
        order_ok = (grant_q.size() == 5);
        if (order_ok) for (int j = 0; j < 5; j++) if (grant_q[j] != j % 4) order_ok = 1'b0;
        checks++;
        if (!order_ok) begin
            failures++;
            $display("FAIL contention_order: got %0d grants %p want 0,1,2,3,0", grant_q.size(), grant_q);
        end
        checks++;
        if (onehot_bad != 0 || hold_bad != 0 || ack_bad != 0) begin
            failures++;
            $display("FAIL contention_gnt_shape: onehot_bad=%0d hold_bad=%0d ack_bad=%0d want 0", onehot_bad, hold_bad, ack_bad);
        end
        checks++;
        if (min_gap != 1) begin failures++; $display("FAIL contention_gap: got %0d want 1", min_gap); end
    endtask

    task automatic test_max();
        bit           got;
        int           gc;
        logic [N-1:0] fg;
        exp_t         e;
        for (int k = 0; k < 8; k++) byte_mem[1][k] = 8'd255;
        eng_lat = 1;
        sb_q.push_back('{id: 1, data: 2040, err: 0});
        req = 4'b0010;
        wait_res(100, 1, got, gc, fg);
        checks++;
        if (!got) begin
            failures++; $display("FAIL max_timeout: no res_valid in 100 cycles");
        end else begin
            e = sb_q.pop_front();
            checks++;
            if ({res_id, res_data, res_err} !== {IDW'(e.id), 11'(e.data), 1'(e.err)}) begin
                failures++;
                $display("FAIL max_result: got id=%0d data=%0d err=%b want id=%0d data=%0d err=%0d",
                         res_id, res_data, res_err, e.id, e.data, e.err);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit           got;
        int           gc, n0;
        logic [N-1:0] fg;
        exp_t         e;
        eng_lat = 2;
        req = 4'b0010;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (gnt != '0) got = 1'b1;
        end
        checks++;
        if (!got) begin failures++; $display("FAIL rstmid_no_grant: gnt stayed 0"); end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        @(negedge clk);
        checks++;
        if ({gnt, sample_ack, eng_go, eng_d, res_valid, res_id, res_data, res_err} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs: gnt=%b ack=%b go=%b d=%0d v=%b id=%0d data=%0d err=%b want all 0",
                     gnt, sample_ack, eng_go, eng_d, res_valid, res_id, res_data, res_err);
        end
        rst_n = 1'b1;
        n0 = res_cnt;
        repeat (20) @(negedge clk);
        checks++;
        if (res_cnt != n0) begin failures++; $display("FAIL rstmid_dropped: got %0d res_valid want 0", res_cnt - n0); end
        sb_q.push_back('{id: 0, data: sum_of(0), err: 0});
        req = '1;
        wait_res(100, 1, got, gc, fg);
        checks++;
        if (fg !== 4'b0001) begin failures++; $display("FAIL rstmid_next_gnt: got %b want 0001", fg); end
        checks++;
        if (!got) begin
            failures++; $display("FAIL rstmid_timeout: no res_valid in 100 cycles");
        end else begin
            e = sb_q.pop_front();
            checks++;
            if ({res_id, res_data, res_err} !== {IDW'(e.id), 11'(e.data), 1'(e.err)}) begin
                failures++;
                $display("FAIL rstmid_result: got id=%0d data=%0d err=%b want id=%0d data=%0d err=%0d",
                         res_id, res_data, res_err, e.id, e.data, e.err);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        bit           got;
        int           gc, n0;
        logic [N-1:0] fg;
        exp_t         e;
        eng_lat = 0;
        sb_q.push_back('{id: 2, data: 0, err: 1});
        req = 4'b0100;
        wait_res(200, 1, got, gc, fg);
        checks++;
        if (!got) begin
            failures++; $display("FAIL timeout_none: no res_valid in 200 cycles");
        end else begin
            e = sb_q.pop_front();
            checks++;
            if ({res_id, res_data, res_err} !== {IDW'(e.id), 11'(e.data), 1'(e.err)}) begin
                failures++;
                $display("FAIL timeout_result: got id=%0d data=%0d err=%b want id=%0d data=%0d err=%0d",
                         res_id, res_data, res_err, e.id, e.data, e.err);
            end
            checks++;
            if (gc != S + T + 1) begin failures++; $display("FAIL timeout_latency: got %0d want %0d", gc, S + T + 1); end
        end
        n0 = res_cnt;
        @(negedge clk);
        inj_req++;
        repeat (6) @(negedge clk);
        checks++;
        if (res_cnt != n0) begin failures++; $display("FAIL timeout_late_valid: got %0d res_valid want 0", res_cnt - n0); end
    endtask

    task automatic test_withdraw();
        bit           got;
        int           gc;
        logic [N-1:0] fg;
        exp_t         e;
        for (int k = 0; k < 8; k++) byte_mem[2][k] = 8'(30 + 3 * k);
        eng_lat = 2;
        sb_q.push_back('{id: 2, data: sum_of(2), err: 0});
        req = 4'b0100;
        wait_res(100, 3, got, gc, fg);
        checks++;
        if (!got) begin
            failures++; $display("FAIL withdraw_timeout: no res_valid in 100 cycles");
        end else begin
            e = sb_q.pop_front();
            checks++;
            if ({res_id, res_data, res_err} !== {IDW'(e.id), 11'(e.data), 1'(e.err)}) begin
                failures++;
                $display("FAIL withdraw_result: got id=%0d data=%0d err=%b want id=%0d data=%0d err=%0d",
                         res_id, res_data, res_err, e.id, e.data, e.err);
            end
        end
        @(negedge clk);
        sb_q.push_back('{id: 3, data: sum_of(3), err: 0});
        req = 4'b1011;
        wait_res(100, 1, got, gc, fg);
        checks++;
        if (fg !== 4'b1000) begin failures++; $display("FAIL withdraw_ptr: got gnt %b want 1000", fg); end
        checks++;
        if (!got) begin
            failures++; $display("FAIL withdraw_next_timeout: no res_valid in 100 cycles");
        end else begin
            e = sb_q.pop_front();
            checks++;
            if ({res_id, res_data, res_err} !== {IDW'(e.id), 11'(e.data), 1'(e.err)}) begin
                failures++;
                $display("FAIL withdraw_next_result: got id=%0d data=%0d err=%b want id=%0d data=%0d err=%0d",
                         res_id, res_data, res_err, e.id, e.data, e.err);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        test_reset();
        test_single();
        test_contention();
        test_max();
        test_reset_mid();
        test_timeout();
        test_withdraw();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
